usb_rx_byte_assembler: RTL

- USB RX stage directly downstream of the EOP detector, and consumer of the same synchronized D+/D- samples and shift_enable strobe.
- Per shift_enable it NRZI-decodes D+, removes stuffed bits, hunts for SYNC, and assembles LSB-first data bytes.
- Uses the `eop` pulse to close the packet.
- Feeds the RX packet FIFO / PID decoder through a one-cycle byte_valid strobe.

---
 rtl/usb_rx_pkg.sv | 14 +
 rtl/usb_rx_bit_unstuffer.sv | 60 ++++++
 rtl/usb_rx_byte_assembler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte path.
// Line states are encoded as {D+, D-}.
package usb_rx_pkg;

    typedef enum logic [2:0] {IDLE, HUNT, DATA, EOPW, ERR, DONE} rx_asm_state_t;

    localparam logic [7:0] SYNC_PATTERN_DEFAULT = 8'h80;
    localparam int         STUFF_RUN_DEFAULT    = 6;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;

endpackage

// File: rtl/usb_rx_bit_unstuffer.sv
// NRZI decoder and bit unstuffer: tracks the previous D+ level and the run of decoded 1s.
// Optional macro USB_RX_STUFF_ERR_EN flags a decoded 1 in the stuffed-bit slot.
module usb_rx_bit_unstuffer
    import usb_rx_pkg::*;
#(
    parameter int STUFF_RUN = STUFF_RUN_DEFAULT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic shift_enable,
    input  logic stuff_en,
    input  logic force_j,
    output logic bit_valid,
    output logic bit_val,
    output logic stuff_violation,
    output logic se0
);

    localparam int OW = $clog2(STUFF_RUN + 1);

    logic          r_prev_dplus;
    logic [OW-1:0] r_ones_cnt;
    logic          w_sample;
    logic          w_stuff_slot;

    assign se0          = ({d_plus_sync, d_minus_sync} == SE0);
    assign bit_val      = (d_plus_sync == r_prev_dplus);
    assign w_sample     = shift_enable && !se0;
    assign w_stuff_slot = stuff_en && (r_ones_cnt == OW'(STUFF_RUN));
    // force_j marks the EOP J sample, which is never data
    assign bit_valid    = w_sample && !force_j && !w_stuff_slot;

`ifdef USB_RX_STUFF_ERR_EN
    assign stuff_violation = w_sample && w_stuff_slot && bit_val;
`else
    assign stuff_violation = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev_dplus <= J[1];
            r_ones_cnt   <= '0;
        end else begin
            if (w_sample)
                r_prev_dplus <= force_j ? J[1] : d_plus_sync;
            // The run only matters inside a packet's data field
            if (!stuff_en)
                r_ones_cnt <= '0;
            else if (w_sample) begin
                if (w_stuff_slot || !bit_val)
                    r_ones_cnt <= '0;
                else
                    r_ones_cnt <= r_ones_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// USB RX byte assembler: SYNC hunt, LSB-first byte assembly and packet framing.
// Optional macro USB_RX_STUFF_ERR_EN enables stuff-violation errors in the unstuffer.
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
    parameter int         MAX_BYTES    = 64,
    parameter int         STUFF_RUN    = STUFF_RUN_DEFAULT
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           d_plus_sync,
    input  logic                           d_minus_sync,
    input  logic                           shift_enable,
    input  logic                           eop,
    output logic [7:0]                     rx_data,
    output logic                           byte_valid,
    output logic                           rx_active,
    output logic                           packet_done,
    output logic                           rx_error,
    output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    rx_asm_state_t r_state;
    rx_asm_state_t w_state_next;

    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_eopw_seen;
    logic [7:0]    r_rx_data;
    logic          r_byte_valid;
    logic          r_rx_active;
    logic          r_rx_error;
    logic [CW-1:0] r_byte_count;

    logic       w_se;
    logic       w_se0;
    logic       w_bit_valid;
    logic       w_bit_val;
    logic       w_stuff_viol;
    logic [7:0] w_shift_next;
    logic       w_full;
    logic       w_start_pkt;
    logic       w_sync_hit;
    logic       w_load_byte;
    logic       w_set_err;

    // eop wins over a coincident bit strobe
    assign w_se = shift_enable && !eop;

    usb_rx_bit_unstuffer #(
        .STUFF_RUN(STUFF_RUN)
    ) u_unstuffer (
        .clk             (clk),
        .n_rst           (n_rst),
        .d_plus_sync     (d_plus_sync),
        .d_minus_sync    (d_minus_sync),
        .shift_enable    (w_se),
        .stuff_en        (r_state == DATA),
        .force_j         ((r_state == EOPW) && !r_eopw_seen),
        .bit_valid       (w_bit_valid),
        .bit_val         (w_bit_val),
        .stuff_violation (w_stuff_viol),
        .se0             (w_se0)
    );

    assign w_shift_next = {w_bit_val, r_shift[7:1]};
    assign w_full       = (r_byte_count == CW'(MAX_BYTES));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start_pkt  = 1'b0;
        w_sync_hit   = 1'b0;
        w_load_byte  = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_se && ({d_plus_sync, d_minus_sync} == K)) begin
                    w_state_next = HUNT;
                    w_start_pkt  = 1'b1;
                end
            end
            HUNT: begin
                if (w_se && w_se0) begin
                    w_state_next = EOPW;
                    w_set_err    = 1'b1;
                end else if (w_bit_valid && (w_shift_next == SYNC_PATTERN)) begin
                    w_state_next = DATA;
                    w_sync_hit   = 1'b1;
                end
            end
            DATA: begin
                if (w_se && w_se0) begin
                    w_state_next = EOPW;
                    w_set_err    = (r_bit_cnt != 3'd0);
                end else if (w_stuff_viol) begin
                    w_state_next = ERR;
                    w_set_err    = 1'b1;
                end else if (w_bit_valid && (r_bit_cnt == 3'd7)) begin
                    if (w_full) begin
                        w_state_next = ERR;
                        w_set_err    = 1'b1;
                    end else begin
                        w_load_byte = 1'b1;
                    end
                end
            end
            EOPW: begin
                if (eop)
                    w_state_next = DONE;
                else if (w_se && !w_se0 && r_eopw_seen) begin
                    w_state_next = ERR;
                    w_set_err    = 1'b1;
                end
            end
            ERR: begin
                if (eop)
                    w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_eopw_seen  <= 1'b0;
            r_rx_data    <= 8'h00;
            r_byte_valid <= 1'b0;
            r_rx_active  <= 1'b0;
            r_rx_error   <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_byte_valid <= w_load_byte;

            // The opening K lands as a 0 in an otherwise empty window
            if (w_start_pkt)
                r_shift <= 8'h00;
            else if (((r_state == HUNT) || (r_state == DATA)) && w_bit_valid)
                r_shift <= w_shift_next;

            if (w_sync_hit)
                r_bit_cnt <= 3'd0;
            else if ((r_state == DATA) && w_bit_valid)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_load_byte)
                r_rx_data <= w_shift_next;

            if (w_start_pkt)
                r_byte_count <= '0;
            else if (w_load_byte)
                r_byte_count <= r_byte_count + 1'b1;

            if (w_start_pkt)
                r_rx_error <= 1'b0;
            else if (w_set_err)
                r_rx_error <= 1'b1;

            // rx_active stays up through the packet_done cycle
            if (w_sync_hit)
                r_rx_active <= 1'b1;
            else if (r_state == DONE)
                r_rx_active <= 1'b0;

            if (r_state != EOPW)
                r_eopw_seen <= 1'b0;
            else if (w_se && !w_se0)
                r_eopw_seen <= 1'b1;
        end
    end

    assign rx_data     = r_rx_data;
    assign byte_valid  = r_byte_valid;
    assign rx_active   = r_rx_active;
    assign packet_done = (r_state == DONE);
    assign rx_error    = r_rx_error;
    assign byte_count  = r_byte_count;

endmodule
